// File: rtl/lutram_refill_pkg.sv
`default_nettype none
//============================================================================
// Module      : refill_pkg
// Description : Shared types and default sizing for the LUTRAM line-refill
//               sequencer.
// Revision    : 1.0 - initial release
//============================================================================
package refill_pkg;

    localparam int WORDS_DEF = 16;
    localparam int DW_DEF    = 32;
    localparam int IW_DEF    = $clog2(WORDS_DEF);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef logic [IW_DEF-1:0] widx_t;

endpackage
`default_nettype wire

// File: rtl/lutram_refill_if.sv
`default_nettype none
//============================================================================
// Module      : lutram_refill_if
// Description : Request, beat, LUTRAM write and status signals of the refill
//               sequencer. slave = sequencer, master = requester/bus/store.
// Revision    : 1.0 - initial release
//============================================================================
interface lutram_refill_if #(
    parameter int WORDS = 16,
    parameter int DW    = 32
);
    localparam int IW = $clog2(WORDS);

    logic              req_valid;
    logic              req_ready;
    logic [IW-1:0]     req_offset;
    logic              beat_valid;
    logic              beat_ready;
    logic [DW-1:0]     beat_data;
    logic              beat_last;
    logic [IW-1:0]     ram_addr;
    logic [DW/8-1:0]   ram_strobe;
    logic [DW-1:0]     ram_wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic              crit_valid;
    logic [DW-1:0]     crit_data;

    modport slave (
        input  req_valid, req_offset, beat_valid, beat_data, beat_last,
        output req_ready, beat_ready, ram_addr, ram_strobe, ram_wdata,
               busy, done, err, crit_valid, crit_data
    );

    modport master (
        output req_valid, req_offset, beat_valid, beat_data, beat_last,
        input  req_ready, beat_ready, ram_addr, ram_strobe, ram_wdata,
               busy, done, err, crit_valid, crit_data
    );

endinterface
`default_nettype wire

// File: rtl/lutram_refill_ctr.sv
`default_nettype none
//============================================================================
// Module      : lutram_refill_ctr
// Description : Base-offset latch and beat counter producing the wrapped
//               LUTRAM address plus first/terminal beat flags.
// Revision    : 1.0 - initial release
//============================================================================
module lutram_refill_ctr
    import refill_pkg::*;
#(
    parameter int WORDS = 16,
    parameter int IW    = $clog2(WORDS)
) (
    input  wire logic          clk,
    input  wire logic          resetn,
    input  wire logic          load,
    input  wire logic [IW-1:0] offset,
    input  wire logic          advance,
    output logic [IW-1:0]      addr,
    output logic               is_first,
    output logic               is_last
);

    logic [IW-1:0] r_base;
    logic [IW-1:0] r_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_base <= '0;
            r_cnt  <= '0;
        end else if (load) begin
            r_base <= offset;
            r_cnt  <= '0;
        end else if (advance) begin
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    // IW-bit add wraps modulo WORDS because WORDS is a power of two
    assign addr     = r_base + r_cnt;
    assign is_first = (r_cnt == '0);
    assign is_last  = (r_cnt == IW'(WORDS - 1));

endmodule
`default_nettype wire

// File: rtl/lutram_refill.sv
`default_nettype none
//============================================================================
// Module      : lutram_refill
// Description : Cache-line refill sequencer writing a bus burst into the
//               LUTRAM line store in critical-word-first wrapping order.
//               Define LUTRAM_REFILL_CRIT_FWD_EN to forward the critical word.
// Revision    : 1.0 - initial release
//============================================================================
module lutram_refill
    import refill_pkg::*;
#(
    parameter int WORDS = WORDS_DEF,
    parameter int DW    = DW_DEF
) (
    input  wire logic       clk,
    input  wire logic       resetn,
    lutram_refill_if.slave  bus
);

    localparam int IW = $clog2(WORDS);
    localparam int SW = DW / 8;

    state_t         r_state;
    state_t         w_state_next;
    logic           r_err;
    logic           w_load;
    logic           w_accept;
    logic           w_term;
    logic [IW-1:0]  w_ctr_addr;
    logic           w_ctr_first;
    logic           w_ctr_last;

    assign w_load   = (r_state == ST_IDLE) && bus.req_valid;
    assign w_accept = (r_state == ST_FILL) && bus.beat_valid;
    assign w_term   = w_accept && (w_ctr_last || bus.beat_last);

    lutram_refill_ctr #(
        .WORDS (WORDS),
        .IW    (IW)
    ) u_ctr (
        .clk      (clk),
        .resetn   (resetn),
        .load     (w_load),
        .offset   (bus.req_offset),
        .advance  (w_accept),
        .addr     (w_ctr_addr),
        .is_first (w_ctr_first),
        .is_last  (w_ctr_last)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (bus.req_valid) w_state_next = ST_FILL;
            ST_FILL: if (w_term)        w_state_next = ST_DONE;
            ST_DONE:                    w_state_next = ST_IDLE;
            default:                    w_state_next = ST_IDLE;
        endcase
    end

    // Length error: the bus "last" flag and our own beat count disagree
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_err <= 1'b0;
        end else if (w_load) begin
            r_err <= 1'b0;
        end else if (w_term) begin
            r_err <= (w_ctr_last != bus.beat_last);
        end
    end

    assign bus.req_ready  = (r_state == ST_IDLE);
    assign bus.beat_ready = (r_state == ST_FILL);
    assign bus.busy       = (r_state == ST_FILL) || (r_state == ST_DONE);
    assign bus.done       = (r_state == ST_DONE);
    assign bus.err        = (r_state == ST_DONE) && r_err;

    // Write port is a straight combinational pass of the accepted beat
    assign bus.ram_addr   = (r_state == ST_FILL) ? w_ctr_addr : '0;
    assign bus.ram_strobe = w_accept ? {SW{1'b1}} : '0;
    assign bus.ram_wdata  = w_accept ? bus.beat_data : '0;

`ifdef LUTRAM_REFILL_CRIT_FWD_EN
    logic          r_crit_valid;
    logic [DW-1:0] r_crit_data;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_crit_valid <= 1'b0;
            r_crit_data  <= '0;
        end else begin
            r_crit_valid <= w_accept && w_ctr_first;
            if (w_accept && w_ctr_first) begin
                r_crit_data <= bus.beat_data;
            end
        end
    end

    assign bus.crit_valid = r_crit_valid;
    assign bus.crit_data  = r_crit_data;
`else
    logic w_unused_first;
    assign w_unused_first = w_ctr_first;
    assign bus.crit_valid = 1'b0;
    assign bus.crit_data  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lutram_refill.sv
`default_nettype none
//============================================================================
// Module      : tb_lutram_refill
// Description : Scoreboard bench for lutram_refill with a behavioural LUTRAM.
// Revision    : 1.0 - initial release
//============================================================================
module tb_lutram_refill;
    import refill_pkg::*;

    logic clk    = 1'b0;
    logic resetn = 1'b0;

    lutram_refill_if #(.WORDS(16), .DW(32)) bus ();

    lutram_refill #(.WORDS(16), .DW(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         wq[$];
    logic        dq[$];
    logic [31:0] cq[$];
    logic [31:0] mem[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural line store fed by the DUT write port
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (bus.ram_strobe[b]) mem[bus.ram_addr][b*8 +: 8] <= bus.ram_wdata[b*8 +: 8];
        end
    end

    wr_t mon_w;
    always @(negedge clk) begin
        if (resetn) begin
            if (bus.ram_strobe != 4'h0) begin
                if (wq.size() == 0) begin
                    check("unexpected_write", 32'(bus.ram_addr), 32'hFFFF_FFFF);
                end else begin
                    mon_w = wq.pop_front();
                    check("wr_addr", 32'(bus.ram_addr), 32'(mon_w.addr));
                    check("wr_data", bus.ram_wdata, mon_w.data);
                    check("wr_strobe", 32'(bus.ram_strobe), 32'hF);
                end
            end
            if (bus.done) begin
                if (dq.size() == 0) check("unexpected_done", 32'(bus.done), 32'h0);
                else                check("done_err", 32'(bus.err), 32'(dq.pop_front()));
            end else if (bus.err) begin
                check("err_without_done", 32'(bus.err), 32'h0);
            end
            if (bus.crit_valid) begin
                if (cq.size() == 0) check("unexpected_crit", bus.crit_data, 32'hFFFF_FFFF);
                else                check("crit_data", bus.crit_data, cq.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic [3:0] off);
        int n = 0;
        bus.req_offset = off;
        bus.req_valid  = 1'b1;
        while (!bus.req_ready && n < 100) begin
            tick();
            n++;
        end
        check("req_timeout", 32'(n >= 100), 32'h0);
        tick();
        bus.req_valid = 1'b0;
        check("busy_after_req", 32'(bus.busy), 32'h1);
    endtask

    // last_at > 15 means the bus never flags a final beat
    task automatic send_line(input logic [3:0] off, input logic [31:0] dbase,
                             input int last_at, input bit gaps);
        int  term = (last_at < 15) ? last_at : 15;
        wr_t w;
        dq.push_back(last_at != 15);
`ifdef LUTRAM_REFILL_CRIT_FWD_EN
        cq.push_back(dbase);
`endif
        for (int i = 0; i <= term; i++) begin
            if (gaps && i > 0) begin
                bus.beat_valid = 1'b0;
                #1;
                check("idle_strobe", 32'(bus.ram_strobe), 32'h0);
                check("idle_addr", 32'(bus.ram_addr), 32'(4'(off + 4'(i))));
                tick();
            end
            bus.beat_valid = 1'b1;
            bus.beat_data  = dbase + 32'(i);
            bus.beat_last  = (i == last_at);
            check("req_ready_fill", 32'(bus.req_ready), 32'h0);
            w.addr = 4'(off + 4'(i));
            w.data = dbase + 32'(i);
            wq.push_back(w);
            tick();
        end
        bus.beat_valid = 1'b0;
        bus.beat_last  = 1'b0;
        check("done_pulse", 32'(bus.done), 32'h1);
        check("req_ready_done", 32'(bus.req_ready), 32'h0);
        tick();
        check("done_clear", 32'(bus.done), 32'h0);
        check("req_ready_back", 32'(bus.req_ready), 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        wr_t w;
        bus.req_valid  = 1'b0;
        bus.req_offset = '0;
        bus.beat_valid = 1'b0;
        bus.beat_data  = '0;
        bus.beat_last  = 1'b0;

        #12;
        check("rst_req_ready", 32'(bus.req_ready), 32'h1);
        check("rst_beat_ready", 32'(bus.beat_ready), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_done_err", 32'({bus.done, bus.err}), 32'h0);
        check("rst_strobe", 32'(bus.ram_strobe), 32'h0);
        check("rst_crit", 32'({31'(bus.crit_data == 0), bus.crit_valid}), 32'h2);
        @(posedge clk); #1;
        resetn = 1'b1;
        tick();

        // Line at offset 0, back-to-back
        do_req(4'd0);
        send_line(4'd0, 32'h1000_0000, 15, 1'b0);
        for (int k = 0; k < 16; k++) check("rb_line0", mem[k], 32'h1000_0000 + 32'(k));

        // Wrapping line from offset 14
        do_req(4'd14);
        send_line(4'd14, 32'h2000_0000, 15, 1'b0);
        check("rb_crit_word14", mem[14], 32'h2000_0000);
        check("rb_wrap_word0", mem[0], 32'h2000_0002);
        check("rb_wrap_word13", mem[13], 32'h2000_000F);

        // Offset 3 with a bubble before every beat after the first
        do_req(4'd3);
        send_line(4'd3, 32'h3000_0000, 15, 1'b1);
        for (int k = 0; k < 16; k++) check("rb_gapped", mem[(3 + k) % 16], 32'h3000_0000 + 32'(k));

        // Early last on beat 5: only 6 words replaced, rest stale
        do_req(4'd0);
        send_line(4'd0, 32'h4000_0000, 5, 1'b0);
        check("rb_early_5", mem[5], 32'h4000_0005);
        check("rb_stale_6", mem[6], 32'h3000_0003);
        check("rb_stale_15", mem[15], 32'h3000_000C);
        do_req(4'd8);
        send_line(4'd8, 32'h5000_0000, 15, 1'b0);
        check("rb_after_err", mem[8], 32'h5000_0000);

        // Missing last, with a competing request held throughout
        do_req(4'd5);
        bus.req_offset = 4'd7;
        bus.req_valid  = 1'b1;
        send_line(4'd5, 32'h6000_0000, 16, 1'b0);
        do_req(4'd7);
        send_line(4'd7, 32'h7000_0000, 15, 1'b0);
        check("rb_held_req", mem[7], 32'h7000_0000);

        // Asynchronous reset after 7 beats of a line at offset 9
        do_req(4'd9);
`ifdef LUTRAM_REFILL_CRIT_FWD_EN
        cq.push_back(32'h8000_0000);
`endif
        for (int i = 0; i < 7; i++) begin
            bus.beat_valid = 1'b1;
            bus.beat_data  = 32'h8000_0000 + 32'(i);
            w.addr = 4'(4'd9 + 4'(i));
            w.data = 32'h8000_0000 + 32'(i);
            wq.push_back(w);
            tick();
        end
        bus.beat_data = 32'h8000_0007;
        #1;
        check("pre_rst_strobe", 32'(bus.ram_strobe), 32'hF);
        resetn = 1'b0;
        #1;
        check("async_rst_strobe", 32'(bus.ram_strobe), 32'h0);
        check("async_rst_state", 32'({bus.busy, bus.beat_ready, bus.req_ready}), 32'h1);
        check("async_rst_done", 32'({bus.done, bus.err, bus.crit_valid}), 32'h0);
        bus.beat_valid = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        check("rb_partial_15", mem[15], 32'h8000_0006);
        check("rb_partial_stale0", mem[0], 32'h7000_0009);
        do_req(4'd2);
        send_line(4'd2, 32'h9000_0000, 15, 1'b0);
        check("rb_restart_2", mem[2], 32'h9000_0000);
        check("rb_restart_1", mem[1], 32'h9000_000F);

        tick();
        check("wq_drained", 32'(wq.size()), 32'h0);
        check("dq_drained", 32'(dq.size()), 32'h0);
        check("cq_drained", 32'(cq.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
